fetch_pc_unit: RTL and testbench
================================

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter WordSize, default 32, SHALL set the width of the PC, addresses and instruction.
REQ-002 Parameter ResetVector, default 0, SHALL set the PC value loaded on reset.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 redirect_valid  input  1  SHALL be the branch-taken redirect request from branch address calc.
REQ-007 redirect_addr  input  WordSize  SHALL be the redirect target; bits [1:0] are forced to 0.
REQ-008 stall  input  1  SHALL be the hazard-unit hold of the handoff to decode.
REQ-009 imem_req_valid  output  1  SHALL be the fetch request valid.
REQ-010 imem_req_ready  input  1  SHALL be the instruction memory request accept.
REQ-011 imem_req_addr  output  WordSize  SHALL be the fetch address, equal to the current PC.
REQ-012 imem_resp_valid  input  1  SHALL mark imem_resp_data valid for one cycle.
REQ-013 imem_resp_data  input  WordSize  SHALL be the fetched instruction.
REQ-014 if_valid, if_pc, if_instr  output  1/WordSize/WordSize  SHALL present the fetched instruction and its PC to decode.
REQ-015 if_ready  input  1  SHALL be the decode accept; handoff occurs when if_valid && if_ready && !stall.

Function
REQ-016 States: REQ_S, WAIT_S, HOLD_S, DROP_S; at most one outstanding memory request.
REQ-017 REQ_S SHALL drive imem_req_valid=1; on redirect_valid, pc<=redirect_addr and next state is DROP_S if imem_req_ready, otherwise REQ_S; without redirect, imem_req_ready moves to WAIT_S.
REQ-018 Instruction memory ignores unaccepted requests, so the request address changing in REQ_S before acceptance is legal.
REQ-019 WAIT_S: resp_valid && redirect SHALL discard data, load pc, go REQ_S; resp_valid alone SHALL capture data into if_instr, go HOLD_S; redirect alone SHALL load pc, go DROP_S.
REQ-020 DROP_S SHALL discard the next response, then go REQ_S; redirect in DROP_S SHALL reload pc and remain until the response arrives.
REQ-021 HOLD_S SHALL drive if_valid=1, with if_pc=pc; redirect SHALL have priority over handoff, dropping the instruction, loading pc and going REQ_S.
REQ-022 Handoff in HOLD_S SHALL set pc<=pc+4 modulo 2^WordSize and go REQ_S; stall or !if_ready SHALL hold all outputs stable.
REQ-023 Latency SHALL be 3 cycles per instruction with a zero-wait-state memory (REQ, WAIT, HOLD).
REQ-024 imem_req_valid SHALL be 0 in every state except REQ_S; if_valid SHALL be 0 in every state except HOLD_S.

Reset
REQ-025 rst SHALL set pc=ResetVector, state=REQ_S, if_instr=0 and all counters to 0; outputs are imem_req_valid=0 and if_valid=0 during the rst cycle.
REQ-026 Reset mid-transaction SHALL abandon the outstanding request, and the first response after reset release SHALL NOT be captured unless a new request was accepted.

Configuration
REQ-027 Macro FETCH_PERF_EN defined SHALL add the outputs perf_redirects and perf_stall_cycles (32 bits each, saturating), counting accepted redirects and HOLD_S cycles blocked by stall or !if_ready.
REQ-028 With FETCH_PERF_EN undefined, those ports and counters SHALL be absent and the behaviour is otherwise identical.

Structure
REQ-029 Package fetch_pkg SHALL hold the fetch_state_t enum and INSTR_BYTES=4.
REQ-030 Sub-module perf_counter (saturating counter with enable) SHALL be instantiated twice, only under FETCH_PERF_EN.

Verification
REQ-031 Reset release, ready memory with 1-cycle response -> requests at 0x0, 0x4 and 0x8 on every third cycle, with if_pc matching.
REQ-032 Redirect to 0x103 in WAIT_S -> next accepted address 0x100; the response for the stale address is dropped, and if_valid never shows it.
REQ-033 Redirect in the same cycle as imem_resp_valid -> data discarded, REQ_S at the target the next cycle.
REQ-034 Stall held 5 cycles in HOLD_S -> if_valid, if_pc and if_instr are stable, no new request, pc unchanged; perf_stall_cycles=5 with FETCH_PERF_EN.
REQ-035 pc=0xFFFFFFFC handed off -> next request at 0x00000000.
REQ-036 rst asserted in WAIT_S with the response arriving 1 cycle later -> the response is ignored, and the first request goes to ResetVector.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch PC unit:
// the fetch state encoding and instruction sizing constants.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ_S  = 2'd0,  // presenting a fetch request at the current PC
        WAIT_S = 2'd1,  // request accepted, waiting for its response
        HOLD_S = 2'd2,  // instruction held for decode until handoff
        DROP_S = 2'd3   // waiting to swallow the response of a squashed request
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;
    localparam int PERF_WIDTH  = 32;

endpackage

// File: rtl/perf_counter.sv
// Saturating event counter: increments by one per enabled cycle and
// sticks at all-ones instead of wrapping.
module perf_counter #(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [Width-1:0] count
);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_d;

    // Next count: add one when enabled unless already saturated.
    always_comb begin
        count_d = count_q;
        if (en && (count_q != {Width{1'b1}})) begin
            count_d = count_q + Width'(1);
        end
    end

    // Counter register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction fetch PC unit: issues one instruction memory request at a
// time, captures the response, and hands it to decode with its PC.
// Branch redirects squash whatever is in flight and restart at the target.
// Optional macro FETCH_PERF_EN adds saturating redirect and
// stall-cycle performance counters on two extra output ports.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int                  WordSize    = 32,
    parameter logic [WordSize-1:0] ResetVector = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_valid,
    input  logic [WordSize-1:0] redirect_addr,
    input  logic                stall,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [WordSize-1:0] imem_req_addr,
    input  logic                imem_resp_valid,
    input  logic [WordSize-1:0] imem_resp_data,
    output logic                if_valid,
    output logic [WordSize-1:0] if_pc,
    output logic [WordSize-1:0] if_instr,
    input  logic                if_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [PERF_WIDTH-1:0] perf_redirects,
    output logic [PERF_WIDTH-1:0] perf_stall_cycles
`endif
);

    // Redirect targets are forced onto an instruction boundary.
    localparam logic [WordSize-1:0] AlignMask = ~WordSize'(INSTR_BYTES - 1);

    fetch_state_t        state_q;
    fetch_state_t        state_d;
    logic [WordSize-1:0] pc_q;
    logic [WordSize-1:0] pc_d;
    logic [WordSize-1:0] instr_q;
    logic [WordSize-1:0] instr_d;

    logic [WordSize-1:0] redirect_tgt;
    logic [WordSize-1:0] pc_plus;
    logic                handoff_ok;

    assign redirect_tgt = redirect_addr & AlignMask;
    assign pc_plus      = pc_q + WordSize'(INSTR_BYTES);
    assign handoff_ok   = if_ready && !stall;

    // Next-state, next-PC and instruction-capture decisions.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            REQ_S: begin
                if (redirect_valid) begin
                    // An accepted request at the old PC must have its response swallowed.
                    pc_d    = redirect_tgt;
                    state_d = imem_req_ready ? DROP_S : REQ_S;
                end else if (imem_req_ready) begin
                    state_d = WAIT_S;
                end
            end
            WAIT_S: begin
                if (imem_resp_valid && redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = REQ_S;
                end else if (imem_resp_valid) begin
                    instr_d = imem_resp_data;
                    state_d = HOLD_S;
                end else if (redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = DROP_S;
                end
            end
            HOLD_S: begin
                // A redirect beats the handoff and drops the held instruction.
                if (redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = REQ_S;
                end else if (handoff_ok) begin
                    pc_d    = pc_plus;
                    state_d = REQ_S;
                end
            end
            DROP_S: begin
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                end
                if (imem_resp_valid) begin
                    state_d = REQ_S;
                end
            end
            default: begin
                state_d = REQ_S;
            end
        endcase
    end

    // State, PC and instruction registers; reset abandons any request in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= REQ_S;
            pc_q    <= ResetVector;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign imem_req_valid = (state_q == REQ_S) && !rst;
    assign imem_req_addr  = pc_q;
    assign if_valid       = (state_q == HOLD_S) && !rst;
    assign if_pc          = pc_q;
    assign if_instr       = instr_q;

`ifdef FETCH_PERF_EN
    logic stall_cycle;

    // A held instruction that decode could not take this cycle.
    assign stall_cycle = (state_q == HOLD_S) && !redirect_valid && !handoff_ok;

    perf_counter #(.Width(PERF_WIDTH)) u_perf_redirects (
        .clk   (clk),
        .rst   (rst),
        .en    (redirect_valid),
        .count (perf_redirects)
    );

    perf_counter #(.Width(PERF_WIDTH)) u_perf_stalls (
        .clk   (clk),
        .rst   (rst),
        .en    (stall_cycle),
        .count (perf_stall_cycles)
    );
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed protocol scenarios followed by a
// randomized run. The reference is the program-order rule: after reset or
// a redirect, decode must receive target, target+4, ... with each
// instruction equal to the memory contents at that address.
module tb_fetch_pc_unit;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        stall;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_redirects;
    logic [31:0] perf_stall_cycles;
`endif

    always #5 clk = ~clk;

    fetch_pc_unit #(.WordSize(32), .ResetVector(RV)) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_addr   (redirect_addr),
        .stall           (stall),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_instr        (if_instr),
        .if_ready        (if_ready)
`ifdef FETCH_PERF_EN
        ,
        .perf_redirects    (perf_redirects),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    int checks = 0;
    int errors = 0;
    int handoffs = 0;
    int cyc = 0;

    // Expected handoff stream (scoreboard).
    logic [31:0] exp_q[$];

    // Memory model state.
    int          mem_lat = 1;
    bit          mem_rand = 1'b0;
    int          lat;
    int          due_q[$];
    logic [31:0] data_q[$];
    bit          acc_seen;
    logic [31:0] acc_addr;

    // Monitor state.
    bit          blk = 1'b0;
    logic [31:0] p_pc;
    logic [31:0] p_in;
    logic [31:0] e_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
        end
    endtask

    task automatic restart_stream(input logic [31:0] t);
        exp_q.delete();
        for (int i = 0; i < 1024; i++) exp_q.push_back(t + 32'(4 * i));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a negedge where a request is being accepted.
    task automatic wait_accept(output int n, output logic [31:0] a);
        bit ok;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 60) begin
            @(negedge clk);
            n++;
            ok = !rst && imem_req_valid && imem_req_ready;
        end
        chk(ok, "accept_timeout", 32'(n), 32'd60);
        a = imem_req_addr;
    endtask

    // Instruction memory: one response per accepted request after a latency.
    initial begin
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        forever begin
            @(negedge clk);
            acc_seen = !rst && imem_req_valid && imem_req_ready;
            acc_addr = imem_req_addr;
            @(posedge clk);
            #1;
            cyc++;
            if (due_q.size() > 0 && due_q[0] < cyc) begin
                void'(due_q.pop_front());
                void'(data_q.pop_front());
            end
            if (acc_seen) begin
                lat = mem_rand ? int'($urandom_range(1, 3)) : mem_lat;
                due_q.push_back(cyc + lat - 1);
                data_q.push_back(mem_word(acc_addr));
            end
            imem_resp_valid = (due_q.size() > 0) && (due_q[0] == cyc);
            imem_resp_data  = imem_resp_valid ? data_q[0] : $urandom;
            imem_req_ready  = (due_q.size() == 0) &&
                              (mem_rand ? ($urandom_range(0, 99) < 70) : 1'b1);
        end
    end

    // Monitor: reset behaviour, hold stability and handoff scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk(!imem_req_valid && !if_valid, "reset_outputs_idle",
                    {30'b0, imem_req_valid, if_valid}, 32'd0);
                blk = 1'b0;
            end else begin
                if (blk) begin
                    chk(if_valid, "hold_valid_stable", {31'b0, if_valid}, 32'd1);
                    chk(if_pc == p_pc, "hold_pc_stable", if_pc, p_pc);
                    chk(if_instr == p_in, "hold_instr_stable", if_instr, p_in);
                    chk(!imem_req_valid, "hold_no_request", {31'b0, imem_req_valid}, 32'd0);
                end
                chk(!(if_valid && imem_req_valid), "req_if_exclusive",
                    {30'b0, imem_req_valid, if_valid}, 32'd0);
                if (if_valid && if_ready && !stall && !redirect_valid) begin
                    chk(exp_q.size() > 0, "stream_nonempty", 32'(exp_q.size()), 32'd1);
                    if (exp_q.size() > 0) begin
                        e_pc = exp_q.pop_front();
                        chk(if_pc == e_pc, "handoff_pc", if_pc, e_pc);
                        chk(if_instr == mem_word(e_pc), "handoff_instr", if_instr, mem_word(e_pc));
                        handoffs++;
                        $display("handoff pc=0x%08h instr=0x%08h", if_pc, if_instr);
                    end
                end
                blk  = if_valid && !redirect_valid && !(if_ready && !stall);
                p_pc = if_pc;
                p_in = if_instr;
            end
        end
    end

    // Stimulus: directed scenarios, then randomized traffic.
    initial begin
        int          n;
        logic [31:0] a;
        logic [31:0] p;
        bit          found;
`ifdef FETCH_PERF_EN
        logic [31:0] perf_base;
`endif
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        stall          = 1'b0;
        if_ready       = 1'b1;
        restart_stream(RV);
        repeat (3) tick();
        rst = 1'b0;

        // Zero-wait memory: requests at RV, RV+4, RV+8, three cycles apart.
        wait_accept(n, a);
        chk(a == RV, "first_req_addr", a, RV);
        chk(n == 1, "first_req_latency", 32'(n), 32'd1);
        for (int i = 1; i < 3; i++) begin
            wait_accept(n, a);
            chk(a == RV + 32'(4 * i), "seq_req_addr", a, RV + 32'(4 * i));
            chk(n == 3, "req_spacing", 32'(n), 32'd3);
        end

        // Redirect to unaligned 0x103 while waiting; stale response must vanish.
        mem_lat = 3;
        tick();
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0103;
        restart_stream(32'h0000_0100);
        tick();
        redirect_valid = 1'b0;
        wait_accept(n, a);
        chk(a == 32'h0000_0100, "redirect_masked_addr", a, 32'h0000_0100);

        // Redirect coincident with the response.
        mem_lat = 1;
        tick();
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0200;
        restart_stream(32'h0000_0200);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk(imem_req_valid && imem_req_addr == 32'h0000_0200, "resp_redirect_req",
            imem_req_addr, 32'h0000_0200);

        // Five stalled HOLD cycles, then handoff.
        tick();
        stall = 1'b1;
`ifdef FETCH_PERF_EN
        perf_base = perf_stall_cycles;
`endif
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            found = if_valid;
        end
        chk(found, "hold_reached", {31'b0, found}, 32'd1);
        p = if_pc;
        chk(p == 32'h0000_0200, "stall_hold_pc", p, 32'h0000_0200);
        repeat (4) begin
            @(negedge clk);
            chk(if_valid && if_pc == p && !imem_req_valid, "stall_hold_state", if_pc, p);
        end
        tick();
        stall = 1'b0;
        tick();
        @(negedge clk);
        chk(imem_req_valid && imem_req_addr == p + 32'd4, "post_stall_next_pc",
            imem_req_addr, p + 32'd4);
`ifdef FETCH_PERF_EN
        chk(perf_stall_cycles - perf_base == 32'd5, "perf_stall_cycles",
            perf_stall_cycles - perf_base, 32'd5);
        chk(perf_redirects == 32'd2, "perf_redirects", perf_redirects, 32'd2);
`endif

        // PC wrap from 0xFFFFFFFC to 0.
        tick();
        redirect_valid = 1'b1;
        redirect_addr  = 32'hFFFF_FFFC;
        restart_stream(32'hFFFF_FFFC);
        tick();
        redirect_valid = 1'b0;
        wait_accept(n, a);
        chk(a == 32'hFFFF_FFFC, "wrap_first_addr", a, 32'hFFFF_FFFC);
        wait_accept(n, a);
        chk(a == 32'h0000_0000, "wrap_next_addr", a, 32'h0000_0000);

        // Reset while waiting; the response lands one cycle after release.
        wait_accept(n, a);
        chk(a == 32'h0000_0004, "pre_reset_addr", a, 32'h0000_0004);
        mem_lat = 2;
        tick();
        rst = 1'b1;
        restart_stream(RV);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk(imem_req_valid && imem_req_addr == RV, "post_reset_req", imem_req_addr, RV);
        chk(!if_valid, "post_reset_no_if", {31'b0, if_valid}, 32'd0);
`ifdef FETCH_PERF_EN
        chk(perf_redirects == 32'd0, "perf_reset", perf_redirects, 32'd0);
`endif
        wait_accept(n, a);
        chk(a == RV, "post_reset_accept", a, RV);

        // Randomized traffic.
        mem_rand = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            tick();
            rst            = ($urandom_range(0, 299) == 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_addr  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                         : $urandom;
            stall          = ($urandom_range(0, 3) == 0);
            if_ready       = ($urandom_range(0, 3) != 0);
            if (rst) restart_stream(RV);
            else if (redirect_valid) restart_stream(redirect_addr & 32'hFFFF_FFFC);
        end
        tick();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        stall          = 1'b0;
        if_ready       = 1'b1;
        repeat (30) tick();
        chk(handoffs > 100, "handoff_progress", 32'(handoffs), 32'd100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
